// File: rtl/gpio_peer_if.sv
// Nibble-link bundle between the CPU GPIO register side and the gpio_peer endpoint.
interface gpio_peer_if;
  logic        gstb;
  logic        gwr;
  logic [3:0]  gpo_in;
  logic [3:0]  gpi_out;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        rx_ovf;
  logic        ovf_clr;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport slave (
    input  gstb, gwr, gpo_in, rx_ready, ovf_clr, tx_data, tx_valid,
    output gpi_out, rx_data, rx_valid, rx_ovf, tx_ready
  );

  modport master (
    output gstb, gwr, gpo_in, rx_ready, ovf_clr, tx_data, tx_valid,
    input  gpi_out, rx_data, rx_valid, rx_ovf, tx_ready
  );
endinterface

// File: rtl/gpio_peer.sv
// Device-side endpoint of the 4-bit GPIO nibble link: CPU writes are framed
// into 32-bit words (RX), local words are served nibble by nibble on CPU reads (TX).
module gpio_peer (
  input  logic      clk,
  input  logic      reset,
  gpio_peer_if.slave bus
);

  typedef enum logic {R_IDLE, R_DATA} rx_state_t;
  typedef enum logic [1:0] {T_EMPTY, T_HDR, T_DATA} tx_state_t;

  localparam logic [3:0] HDR = 4'hA;

  rx_state_t   r_state, r_next;
  logic [2:0]  r_cnt;
  logic        wr_d;
  logic [27:0] asm_q;
  logic [31:0] rx_data_q;
  logic        rx_valid_q;
  logic        rx_ovf_q;
  logic        wr_ev, rx_complete, rx_load, rx_consume;

  tx_state_t   t_state, t_next;
  logic [2:0]  t_cnt;
  logic [31:0] t_shift;
  logic        rd_ev, tx_load;

  // Delay the write strobe one cycle so gpo_in is sampled after the CPU register updates
  always_ff @(posedge clk) begin
    if (reset) wr_d <= 1'b0;
    else       wr_d <= bus.gstb & bus.gwr;
  end

  // RX event decode and word completion/overflow qualification
  always_comb begin
    wr_ev       = wr_d;
    rx_complete = wr_ev && (r_state == R_DATA) && (r_cnt == 3'd7);
    rx_consume  = rx_valid_q && bus.rx_ready;
    rx_load     = rx_complete && (!rx_valid_q || bus.rx_ready);
  end

  // RX state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= R_IDLE;
    else       r_state <= r_next;
  end

  // RX next-state: header opens a frame, eighth data nibble closes it
  always_comb begin
    r_next = r_state;
    unique case (r_state)
      R_IDLE: if (wr_ev && bus.gpo_in == HDR) r_next = R_DATA;
      R_DATA: if (rx_complete)                r_next = R_IDLE;
      default:                                r_next = R_IDLE;
    endcase
  end

  // RX datapath: nibble assembly, output word, valid and sticky overflow
  // Nibbles 0..6 are shifted in from the top so that after seven shifts they sit
  // at [27:0]; the eighth nibble is taken straight from gpo_in as bits [31:28].
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      asm_q      <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ovf_q   <= 1'b0;
    end else begin
      if (r_state == R_IDLE) begin
        if (wr_ev && bus.gpo_in == HDR) r_cnt <= '0;
      end else if (wr_ev) begin
        r_cnt <= r_cnt + 3'd1;
        if (!rx_complete) asm_q <= {bus.gpo_in, asm_q[27:4]};
      end

      if (rx_load)         rx_data_q <= {bus.gpo_in, asm_q};

      if (rx_load)         rx_valid_q <= 1'b1;
      else if (rx_consume) rx_valid_q <= 1'b0;

      if (rx_complete && !rx_load) rx_ovf_q <= 1'b1;
      else if (bus.ovf_clr)        rx_ovf_q <= 1'b0;
    end
  end

  // TX event decode
  always_comb begin
    rd_ev   = bus.gstb & ~bus.gwr;
    tx_load = (t_state == T_EMPTY) && bus.tx_valid;
  end

  // TX state register
  always_ff @(posedge clk) begin
    if (reset) t_state <= T_EMPTY;
    else       t_state <= t_next;
  end

  // TX next-state: load, header read, eight data reads
  always_comb begin
    t_next = t_state;
    unique case (t_state)
      T_EMPTY: if (tx_load)                    t_next = T_HDR;
      T_HDR:   if (rd_ev)                      t_next = T_DATA;
      T_DATA:  if (rd_ev && t_cnt == 3'd7)     t_next = T_EMPTY;
      default:                                 t_next = T_EMPTY;
    endcase
  end

  // TX datapath: word capture and nibble shifting on reads
  always_ff @(posedge clk) begin
    if (reset) begin
      t_cnt   <= '0;
      t_shift <= '0;
    end else if (tx_load) begin
      t_shift <= bus.tx_data;
    end else if (rd_ev && t_state == T_HDR) begin
      t_cnt <= '0;
    end else if (rd_ev && t_state == T_DATA) begin
      t_shift <= {4'h0, t_shift[31:4]};
      t_cnt   <= t_cnt + 3'd1;
    end
  end

  // Outputs: gpi_out depends on registered state only, never on gstb
  always_comb begin
    bus.tx_ready = (t_state == T_EMPTY);
    unique case (t_state)
      T_HDR:   bus.gpi_out = HDR;
      T_DATA:  bus.gpi_out = t_shift[3:0];
      default: bus.gpi_out = 4'h0;
    endcase
    bus.rx_data  = rx_data_q;
    bus.rx_valid = rx_valid_q;
    bus.rx_ovf   = rx_ovf_q;
  end

endmodule

// File: tb/tb_gpio_peer.sv
// Self-checking bench for gpio_peer: directed corner sequences plus a vector
// table of concurrent RX/TX words, with queued expectations for both directions.
module tb_gpio_peer;

  logic clk = 1'b0;
  logic reset;

  gpio_peer_if bus ();

  gpio_peer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [35:0] rx_nibs;   // nibble i written at [4*i+3:4*i], header first
    logic [31:0] rx_exp;    // word that must appear on rx_data
    logic [31:0] tx_word;   // word offered on tx_data
    logic [35:0] tx_exp;    // nibble i expected on read i
    logic        b2b;       // 1: all writes back-to-back, then all reads
  } vec_t;

  int nvec = 0;
  int nerr = 0;
  logic [31:0] rx_q[$];
  logic [3:0]  tx_q[$];
  vec_t        tv[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] n);
    bus.gstb = 1'b1;
    bus.gwr  = 1'b1;
    cyc();
    bus.gstb   = 1'b0;
    bus.gpo_in = n;
  endtask

  task automatic rd();
    logic [3:0] e;
    bus.gstb = 1'b1;
    bus.gwr  = 1'b0;
    @(negedge clk);
    if (tx_q.size() == 0) begin
      nvec++;
      nerr++;
      $display("FAIL tx_spurious: got read with no expectation queued, gpi_out=%h", bus.gpi_out);
    end else begin
      e = tx_q.pop_front();
      chk("tx_nibble", {28'h0, bus.gpi_out}, {28'h0, e});
    end
    cyc();
    bus.gstb = 1'b0;
  endtask

  task automatic frame(input logic [31:0] w);
    wr(4'hA);
    for (int i = 0; i < 8; i++) wr(w[4*i +: 4]);
  endtask

  task automatic push_tx(input logic [31:0] w);
    tx_q.push_back(4'hA);
    for (int i = 0; i < 8; i++) tx_q.push_back(w[4*i +: 4]);
  endtask

  // RX scoreboard: every consume handshake must deliver the next queued word
  always @(negedge clk) begin
    if (!reset && bus.rx_valid && bus.rx_ready) begin
      if (rx_q.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL rx_spurious: got word %h with none expected", bus.rx_data);
      end else begin
        chk("rx_word", bus.rx_data, rx_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    tv[0] = '{36'h12345678A, 32'h12345678, 32'hDEADBEEF, 36'hDEADBEEFA, 1'b0};
    tv[1] = '{36'h00000000A, 32'h00000000, 32'hFFFFFFFF, 36'hFFFFFFFFA, 1'b1};
    tv[2] = '{36'hFEDCBA98A, 32'hFEDCBA98, 32'h00000000, 36'h00000000A, 1'b0};
    tv[3] = '{36'hA5A5A5A5A, 32'hA5A5A5A5, 32'h13579BDF, 36'h13579BDFA, 1'b1};

    reset = 1'b1;
    bus.gstb = 1'b0; bus.gwr = 1'b0; bus.gpo_in = 4'h0;
    bus.rx_ready = 1'b0; bus.ovf_clr = 1'b0;
    bus.tx_data = '0; bus.tx_valid = 1'b0;
    repeat (3) cyc();
    @(negedge clk);
    chk("rst_gpi_out",  {28'h0, bus.gpi_out}, 32'h0);
    chk("rst_rx_data",  bus.rx_data, 32'h0);
    chk("rst_rx_valid", {31'h0, bus.rx_valid}, 32'h0);
    chk("rst_rx_ovf",   {31'h0, bus.rx_ovf}, 32'h0);
    chk("rst_tx_ready", {31'h0, bus.tx_ready}, 32'h1);
    cyc();
    reset = 1'b0;
    cyc();

    // RX word with rx_ready low: valid exactly two cycles after last strobe
    wr(4'hA); wr(4'h8); wr(4'h7); wr(4'h6); wr(4'h5);
    wr(4'h4); wr(4'h3); wr(4'h2); wr(4'h1);
    @(negedge clk);
    chk("rx_valid_early", {31'h0, bus.rx_valid}, 32'h0);
    cyc();
    @(negedge clk);
    chk("rx_valid_lat", {31'h0, bus.rx_valid}, 32'h1);
    chk("rx_data_lat",  bus.rx_data, 32'h12345678);
    cyc();
    rx_q.push_back(32'h12345678);
    bus.rx_ready = 1'b1;
    cyc();
    bus.rx_ready = 1'b0;
    @(negedge clk);
    chk("rx_valid_clear", {31'h0, bus.rx_valid}, 32'h0);
    cyc();

    // Overflow: second frame dropped, first word kept
    frame(32'h11111111);
    cyc();
    @(negedge clk);
    chk("ovf_first_valid", {31'h0, bus.rx_valid}, 32'h1);
    chk("ovf_first_data",  bus.rx_data, 32'h11111111);
    cyc();
    frame(32'h22222222);
    cyc();
    @(negedge clk);
    chk("ovf_data_kept", bus.rx_data, 32'h11111111);
    chk("ovf_set",       {31'h0, bus.rx_ovf}, 32'h1);
    cyc();
    bus.ovf_clr = 1'b1;
    cyc();
    bus.ovf_clr = 1'b0;
    @(negedge clk);
    chk("ovf_cleared", {31'h0, bus.rx_ovf}, 32'h0);
    cyc();

    // Consume in the completion cycle: new word loads, no overflow
    frame(32'h33333333);
    rx_q.push_back(32'h11111111);
    bus.rx_ready = 1'b1;
    cyc();
    bus.rx_ready = 1'b0;
    @(negedge clk);
    chk("cc_valid", {31'h0, bus.rx_valid}, 32'h1);
    chk("cc_data",  bus.rx_data, 32'h33333333);
    chk("cc_no_ovf", {31'h0, bus.rx_ovf}, 32'h0);
    cyc();
    rx_q.push_back(32'h33333333);
    bus.rx_ready = 1'b1;
    cyc();
    bus.rx_ready = 1'b0;

    // Overflow and ovf_clr in the same cycle: set wins
    frame(32'h55555555);
    cyc();
    frame(32'h66666666);
    bus.ovf_clr = 1'b1;
    cyc();
    bus.ovf_clr = 1'b0;
    @(negedge clk);
    chk("ovf_set_wins", {31'h0, bus.rx_ovf}, 32'h1);
    chk("ovf_sw_data",  bus.rx_data, 32'h55555555);
    cyc();
    bus.ovf_clr = 1'b1;
    cyc();
    bus.ovf_clr = 1'b0;
    rx_q.push_back(32'h55555555);
    bus.rx_ready = 1'b1;
    cyc();
    bus.rx_ready = 1'b0;
    @(negedge clk);
    chk("sw_valid_clear", {31'h0, bus.rx_valid}, 32'h0);
    chk("sw_ovf_clear",   {31'h0, bus.rx_ovf}, 32'h0);
    cyc();

    // TX word
    bus.tx_data  = 32'hDEADBEEF;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    chk("tx_ready_idle", {31'h0, bus.tx_ready}, 32'h1);
    cyc();
    bus.tx_valid = 1'b0;
    @(negedge clk);
    chk("tx_ready_busy", {31'h0, bus.tx_ready}, 32'h0);
    chk("tx_hdr_lat",    {28'h0, bus.gpi_out}, 32'hA);
    cyc();
    push_tx(32'hDEADBEEF);
    repeat (9) rd();
    @(negedge clk);
    chk("tx_ready_back", {31'h0, bus.tx_ready}, 32'h1);
    cyc();
    tx_q.push_back(4'h0);
    rd();

    // Garbage in R_IDLE never opens a frame
    wr(4'h3); wr(4'hF);
    for (int i = 1; i <= 8; i++) wr(4'(i));
    cyc();
    cyc();
    @(negedge clk);
    chk("garbage_no_word", {31'h0, bus.rx_valid}, 32'h0);
    cyc();

    // Read in T_EMPTY coinciding with a load returns 0; next read is the header
    bus.tx_data  = 32'hCAFEF00D;
    bus.tx_valid = 1'b1;
    tx_q.push_back(4'h0);
    rd();
    bus.tx_valid = 1'b0;
    push_tx(32'hCAFEF00D);
    repeat (9) rd();

    // Reset with partial frames in both directions
    frame(32'h77777777);
    cyc();
    wr(4'hA); wr(4'h1); wr(4'h2);
    bus.tx_data  = 32'h12345678;
    bus.tx_valid = 1'b1;
    cyc();
    bus.tx_valid = 1'b0;
    tx_q.push_back(4'hA);
    tx_q.push_back(4'h8);
    rd();
    rd();
    reset = 1'b1;
    cyc();
    @(negedge clk);
    chk("mid_rst_gpi_out",  {28'h0, bus.gpi_out}, 32'h0);
    chk("mid_rst_rx_data",  bus.rx_data, 32'h0);
    chk("mid_rst_rx_valid", {31'h0, bus.rx_valid}, 32'h0);
    chk("mid_rst_rx_ovf",   {31'h0, bus.rx_ovf}, 32'h0);
    chk("mid_rst_tx_ready", {31'h0, bus.tx_ready}, 32'h1);
    cyc();
    reset = 1'b0;
    tx_q.push_back(4'h0);
    rd();
    rx_q.push_back(32'h9ABCDEF0);
    bus.rx_ready = 1'b1;
    frame(32'h9ABCDEF0);
    repeat (3) cyc();

    // Vector table: concurrent RX and TX words, alternating or back-to-back
    for (int v = 0; v < 4; v++) begin
      bus.tx_data  = tv[v].tx_word;
      bus.tx_valid = 1'b1;
      @(negedge clk);
      chk("tbl_tx_ready", {31'h0, bus.tx_ready}, 32'h1);
      cyc();
      bus.tx_valid = 1'b0;
      rx_q.push_back(tv[v].rx_exp);
      if (tv[v].b2b) begin
        for (int i = 0; i < 9; i++) wr(tv[v].rx_nibs[4*i +: 4]);
        for (int i = 0; i < 9; i++) begin
          tx_q.push_back(tv[v].tx_exp[4*i +: 4]);
          rd();
        end
      end else begin
        for (int i = 0; i < 9; i++) begin
          wr(tv[v].rx_nibs[4*i +: 4]);
          tx_q.push_back(tv[v].tx_exp[4*i +: 4]);
          rd();
        end
      end
      repeat (3) cyc();
      @(negedge clk);
      chk("tbl_tx_done", {31'h0, bus.tx_ready}, 32'h1);
      cyc();
    end
    bus.rx_ready = 1'b0;

    chk("rx_q_drained", rx_q.size(), 32'd0);
    chk("tx_q_drained", tx_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
